dual_issue_inst_queue: RTL and testbench
========================================

# dual_issue_inst_queue

Parametrised circular instruction queue between fetch and the dual-issue dispatch stage. Fetch pushes up to two instructions per cycle; dispatch sees the two oldest entries as show-ahead outputs and retires 0, 1 or 2 per cycle under in-order stall control. Unlike the earlier fixed 256-entry preloaded queue, it has a real write port, occupancy and valid tracking, backpressure, flush and reset.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 16, entry count; power of two, at least 4
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch mispredict)
- wr_en1  in  1  push request, slot 1
- wr_data1  in  DATA_W  instruction, slot 1 (older)
- wr_en2  in  1  push request, slot 2; honoured only with wr_en1
- wr_data2  in  DATA_W  instruction, slot 2 (younger)
- wr_ready1  out  1  at least 1 free entry
- wr_ready2  out  1  at least 2 free entries
- stall1  in  1  dispatch cannot take inst1
- stall2  in  1  dispatch cannot take inst2
- inst1  out  DATA_W  entry at head
- inst2  out  DATA_W  entry at head+1
- valid1, valid2  out  1  inst1 / inst2 hold live entries
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- full, empty  out  1  count==DEPTH / count==0
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Storage: DEPTH x DATA_W array; head and tail pointers ADDR_W bits, wrap modulo DEPTH naturally.
- Pop: pop1 = valid1 & ~stall1; pop2 = pop1 & valid2 & ~stall2. Slot 2 never issues ahead of slot 1. Head advances by pop1+pop2.
- Push: push1 = wr_en1 & wr_ready1; push2 = wr_en1 & wr_en2 & wr_ready2. wr_data1 at tail, wr_data2 at tail+1; tail advances by push1+push2. wr_en2 without wr_en1 is ignored.
- Ready is computed from occupancy at the start of the cycle. Same-cycle pops do not free space for same-cycle pushes.
- A push with insufficient space is dropped whole: with wr_en1&wr_en2 and one free entry, only slot 1 is written.
- count_next = count + pushes - pops; the simultaneous push and pop in one cycle is legal at any occupancy.
- Outputs are show-ahead and combinational from head: valid1 = count>=1, valid2 = count>=2. When invalid, inst1/inst2 drive 0.
- Priority: rst > flush > normal operation. Flush zeroes head, tail and count; same-cycle pushes and pops are discarded. Array contents are not cleared.

## Timing
- Reset (sync): head=tail=count=0; empty=1; full=0; valid1=valid2=0; inst1=inst2=0; wr_ready1=wr_ready2=1; err=0. Reset mid-operation discards all entries on that edge.
- Push-to-visible latency: 1 cycle. Data pushed at edge N is on inst1/inst2 after edge N when the queue was empty before the push.
- There is no empty-bypass: a push into an empty queue never appears on the outputs in the same cycle.
- Pop takes effect at the edge. The next entries are visible immediately after it.
- Flush: outputs are invalid in the cycle after the flush edge.

## Configuration
- INSTQ_PROTOCOL_CHECK_EN defined: err sets on any edge (rst low) with one of the following, and holds until rst:
  - wr_en1 & ~wr_ready1
  - wr_en1 & wr_en2 & ~wr_ready2
  - wr_en2 & ~wr_en1
- INSTQ_PROTOCOL_CHECK_EN undefined: err is tied to 0 and no checking logic is built.

## Test plan
- Reset, then push 0x11,0x22 together -> next cycle valid1=valid2=1, inst1=0x11, inst2=0x22, count=2.
- Queue holds A,B,C with stall1=0, stall2=1 -> one edge retires A only; then inst1=B, inst2=C, count=2. With stall1=1, stall2=0 -> nothing retires.
- DEPTH=8: fill to 7, push pair -> only wr_data1 stored, count=8, full=1, wr_ready1=0. With INSTQ_PROTOCOL_CHECK_EN, err=1.
- Wrap-around: 20 cycles of dual push/dual pop with DEPTH=8 and sequential data 1..40 -> in-order output, count steady at 2.
- At count=5, flush with a simultaneous push pair and pop -> count=0, empty=1, valid1=0 next cycle.
- At count=8, push pair plus dual pop in the same cycle -> pushes dropped, count=6.

Source files
------------

// File: rtl/dual_issue_inst_queue.sv
// Circular instruction queue: two-wide push from fetch, two show-ahead heads for in-order dual dispatch.
// Optional INSTQ_PROTOCOL_CHECK_EN builds a sticky protocol-error flag; otherwise err is tied low.
module dual_issue_inst_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              wr_en2,
  input  logic [DATA_W-1:0] wr_data2,
  output logic              wr_ready1,
  output logic              wr_ready2,
  input  logic              stall1,
  input  logic              stall2,
  output logic [DATA_W-1:0] inst1,
  output logic [DATA_W-1:0] inst2,
  output logic              valid1,
  output logic              valid2,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] head_reg, head_next, tail_reg, tail_next;
  logic [ADDR_W-1:0] head_p1, tail_p1;
  logic [CW-1:0]     count_reg, count_next;
  logic              pop1, pop2, push1, push2;

  assign head_p1 = head_reg + PTR_ONE;
  assign tail_p1 = tail_reg + PTR_ONE;

  // Status derives only from start-of-cycle occupancy, so same-cycle pops never free room for pushes.
  assign count     = count_reg;
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign valid1    = !empty;
  assign valid2    = (count_reg >= CW'(2));
  assign wr_ready1 = !full;
  assign wr_ready2 = (count_reg <= CW'(DEPTH - 2));

  assign inst1 = valid1 ? mem[head_reg] : '0;
  assign inst2 = valid2 ? mem[head_p1]  : '0;

  assign pop1  = valid1 & ~stall1;
  assign pop2  = pop1 & valid2 & ~stall2;
  assign push1 = wr_en1 & wr_ready1;
  assign push2 = wr_en1 & wr_en2 & wr_ready2;

  always_comb begin
    head_next  = head_reg + ADDR_W'(pop1) + ADDR_W'(pop2);
    tail_next  = tail_reg + ADDR_W'(push1) + ADDR_W'(push2);
    count_next = count_reg + CW'(push1) + CW'(push2) - CW'(pop1) - CW'(pop2);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push1) mem[tail_reg] <= wr_data1;
      if (push2) mem[tail_p1]  <= wr_data2;
    end
  end

`ifdef INSTQ_PROTOCOL_CHECK_EN
  logic err_reg;
  always_ff @(posedge clk) begin
    if (rst)
      err_reg <= 1'b0;
    else if ((wr_en1 & ~wr_ready1) | (wr_en1 & wr_en2 & ~wr_ready2) | (wr_en2 & ~wr_en1))
      err_reg <= 1'b1;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_issue_inst_queue.sv
// Self-checking bench for dual_issue_inst_queue (DEPTH=8): directed vector table, wrap sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_dual_issue_inst_queue;
  localparam int DW = 32;
  localparam int DEPTH = 8;
`ifdef INSTQ_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, wr_en1, wr_en2, stall1, stall2;
  logic [DW-1:0] wr_data1, wr_data2;
  logic          wr_ready1, wr_ready2, valid1, valid2, full, empty, err;
  logic [DW-1:0] inst1, inst2;
  logic [3:0]    count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dual_issue_inst_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en1(wr_en1), .wr_data1(wr_data1), .wr_en2(wr_en2), .wr_data2(wr_data2),
    .wr_ready1(wr_ready1), .wr_ready2(wr_ready2),
    .stall1(stall1), .stall2(stall2),
    .inst1(inst1), .inst2(inst2), .valid1(valid1), .valid2(valid2),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  typedef struct {
    logic          fl, e1, e2;
    logic [DW-1:0] d1, d2;
    logic          s1, s2;
    int            cnt;
    logic [DW-1:0] i1, i2;
    logic          perr;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input logic [DW-1:0] i1,
                           input logic [DW-1:0] i2, input logic e);
    chk({tag, ".count"},     DW'(count),     DW'(cnt));
    chk({tag, ".valid1"},    DW'(valid1),    DW'(cnt >= 1));
    chk({tag, ".valid2"},    DW'(valid2),    DW'(cnt >= 2));
    chk({tag, ".inst1"},     inst1,          i1);
    chk({tag, ".inst2"},     inst2,          i2);
    chk({tag, ".full"},      DW'(full),      DW'(cnt == DEPTH));
    chk({tag, ".empty"},     DW'(empty),     DW'(cnt == 0));
    chk({tag, ".wr_ready1"}, DW'(wr_ready1), DW'(cnt <= DEPTH - 1));
    chk({tag, ".wr_ready2"}, DW'(wr_ready2), DW'(cnt <= DEPTH - 2));
    chk({tag, ".err"},       DW'(err),       DW'(CHK & e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; wr_en1 = 0; wr_en2 = 0; stall1 = 0; stall2 = 0;
    wr_data1 = '0; wr_data2 = '0;
  endtask

  // reference model state
  logic [DW-1:0] q[$];
  logic          m_err;

  task automatic model_edge();
    int free;
    bit p1, p2;
    if (rst) begin
      q.delete();
      m_err = 0;
      return;
    end
    free = DEPTH - q.size();
    if ((wr_en1 && free < 1) || (wr_en1 && wr_en2 && free < 2) || (wr_en2 && !wr_en1)) m_err = 1;
    if (flush) begin
      q.delete();
      return;
    end
    p1 = (q.size() >= 1) && !stall1;
    p2 = p1 && (q.size() >= 2) && !stall2;
    if (p1) void'(q.pop_front());
    if (p2) void'(q.pop_front());
    if (wr_en1 && free >= 1) q.push_back(wr_data1);
    if (wr_en1 && wr_en2 && free >= 2) q.push_back(wr_data2);
  endtask

  initial begin
    idle_inputs();
    m_err = 0;

    vecs[0]  = '{0, 1, 1, 32'h11, 32'h22, 0, 0, 2, 32'h11, 32'h22, 0};
    vecs[1]  = '{0, 1, 0, 32'h33, 32'h00, 1, 1, 3, 32'h11, 32'h22, 0};
    vecs[2]  = '{0, 0, 0, 32'h00, 32'h00, 0, 1, 2, 32'h22, 32'h33, 0};
    vecs[3]  = '{0, 0, 0, 32'h00, 32'h00, 1, 0, 2, 32'h22, 32'h33, 0};
    vecs[4]  = '{0, 1, 1, 32'h44, 32'h55, 1, 1, 4, 32'h22, 32'h33, 0};
    vecs[5]  = '{0, 1, 0, 32'h66, 32'h00, 1, 1, 5, 32'h22, 32'h33, 0};
    vecs[6]  = '{1, 1, 1, 32'h77, 32'h88, 0, 0, 0, 32'h00, 32'h00, 0};
    vecs[7]  = '{0, 1, 1, 32'h01, 32'h02, 0, 0, 2, 32'h01, 32'h02, 0};
    vecs[8]  = '{0, 1, 1, 32'h03, 32'h04, 1, 1, 4, 32'h01, 32'h02, 0};
    vecs[9]  = '{0, 1, 1, 32'h05, 32'h06, 1, 1, 6, 32'h01, 32'h02, 0};
    vecs[10] = '{0, 1, 0, 32'h07, 32'h00, 1, 1, 7, 32'h01, 32'h02, 0};
    vecs[11] = '{0, 1, 1, 32'h08, 32'h09, 1, 1, 8, 32'h01, 32'h02, 1};
    vecs[12] = '{0, 1, 1, 32'hAA, 32'hBB, 0, 0, 6, 32'h03, 32'h04, 1};
    vecs[13] = '{0, 0, 0, 32'h00, 32'h00, 0, 0, 4, 32'h05, 32'h06, 1};
    vecs[14] = '{0, 0, 0, 32'h00, 32'h00, 0, 0, 2, 32'h07, 32'h08, 1};
    vecs[15] = '{0, 0, 0, 32'h00, 32'h00, 0, 0, 0, 32'h00, 32'h00, 1};
    vecs[16] = '{0, 0, 1, 32'h00, 32'h99, 0, 0, 0, 32'h00, 32'h00, 1};

    // reset state
    rst = 1;
    step();
    step();
    rst = 0;
    check_all("reset", 0, '0, '0, 0);
    $display("[TB] reset checked");

    for (int i = 0; i < 17; i++) begin
      flush = vecs[i].fl; wr_en1 = vecs[i].e1; wr_en2 = vecs[i].e2;
      wr_data1 = vecs[i].d1; wr_data2 = vecs[i].d2;
      stall1 = vecs[i].s1; stall2 = vecs[i].s2;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].i1, vecs[i].i2, vecs[i].perr);
      $display("[TB] vec%0d fl=%0b en=%0b%0b d=%h/%h st=%0b%0b -> count=%0d inst=%h/%h",
               i, vecs[i].fl, vecs[i].e1, vecs[i].e2, vecs[i].d1, vecs[i].d2,
               vecs[i].s1, vecs[i].s2, count, inst1, inst2);
    end

    // mid-operation reset discards entries and clears err
    idle_inputs();
    wr_en1 = 1; wr_en2 = 1; wr_data1 = 32'h5; wr_data2 = 32'h6;
    step();
    rst = 1; wr_data1 = 32'h7; wr_data2 = 32'h8;
    step();
    idle_inputs();
    check_all("midreset", 0, '0, '0, 0);
    $display("[TB] mid-operation reset -> count=%0d", count);

    // wrap-around: steady dual push / dual pop with sequential data
    wr_en1 = 1; wr_en2 = 1; wr_data1 = 1; wr_data2 = 2;
    step();
    check_all("wrap0", 2, 1, 2, 0);
    for (int k = 1; k < 20; k++) begin
      wr_data1 = DW'(2 * k + 1);
      wr_data2 = DW'(2 * k + 2);
      step();
      check_all($sformatf("wrap%0d", k), 2, DW'(2 * k + 1), DW'(2 * k + 2), 0);
      $display("[TB] wrap%0d -> count=%0d inst=%0d/%0d", k, count, inst1, inst2);
    end

    // randomized traffic against the queue model
    idle_inputs();
    rst = 1;
    step();
    q.delete();
    m_err = 0;
    rst = 0;
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 99) < 2);
      wr_en1   = ($urandom_range(0, 99) < 65);
      wr_en2   = ($urandom_range(0, 99) < 55);
      stall1   = ($urandom_range(0, 99) < 35);
      stall2   = ($urandom_range(0, 99) < 35);
      wr_data1 = $urandom;
      wr_data2 = $urandom;
      model_edge();
      step();
      check_all($sformatf("rand%0d", c), q.size(),
                (q.size() >= 1) ? q[0] : '0, (q.size() >= 2) ? q[1] : '0, m_err);
      $display("[TB] rand%0d rst=%0b fl=%0b en=%0b%0b st=%0b%0b -> count=%0d exp=%0d",
               c, rst, flush, wr_en1, wr_en2, stall1, stall2, count, q.size());
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
